serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Parallel-to-serial frame transmitter for the 74LSXX library: accepts a data word on a load/ready handshake and shifts it out on a single serial line as start bit, data bits LSB first, stop bit. It is the driving end of the serial links that the library's D flip-flop and shift-register receiver models capture. Each bit is held for a programmable number of clock cycles. Outputs are complementary `Q`/`Q_n`, matching the library's flip-flop pinout.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 1..16.
- `CLKS_PER_BIT`, default 4: clock cycles each serial bit is held; legal range 1..65535.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `CLR`  in  1  reset; one clock, synchronous, active-high.
- `LOAD`  in  1  request to transmit `D`; sampled only while `READY`=1.
- `D`  in  `DATA_BITS`  word to transmit; captured on the accepting edge.
- `READY`  out  1  transmitter idle and able to accept `LOAD`.
- `Q`  out  1  serial line; idles high.
- `Q_n`  out  1  always the complement of `Q`.
- `BUSY`  out  1  frame in progress; always the complement of `READY`.
- `DONE`  out  1  one-cycle pulse in the final cycle of the stop bit.

## Operation
- Reset values: `Q`=1, `Q_n`=0, `READY`=1, `BUSY`=0, `DONE`=0, state IDLE, counters 0.
- `CLR` dominates every other input on the same edge, including mid-frame: the frame is abandoned at the next edge with no `DONE` pulse.
- States: IDLE → START → DATA → STOP → IDLE.
- **IDLE:** `Q`=1, `READY`=1.
  - Acceptance = rising edge with `READY`=1 and `LOAD`=1.
  - On acceptance, latch `D` into the shift register, go to START and drive `Q`=0.
  - `LOAD` while `READY`=0 is ignored; it is neither queued nor counted.
- **START:** hold `Q`=0 for `CLKS_PER_BIT` cycles, then go to DATA with `Q` = bit 0.
- **DATA:**
  - Hold each bit for `CLKS_PER_BIT` cycles, LSB first.
  - Shift right after each bit; the bit counter counts 0..`DATA_BITS`-1.
  - After the last bit, go to STOP with `Q`=1.
- **STOP:**
  - Hold `Q`=1 for `CLKS_PER_BIT` cycles.
  - `DONE`=1 during the last of these cycles.
  - Return to IDLE with `READY`=1.
- Counters:
  - Bit-time counter counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at every bit boundary; it is sized ceil(log2(`CLKS_PER_BIT`+1)).
  - Bit counter is sized ceil(log2(`DATA_BITS`+1)).
- `CLKS_PER_BIT`=1 is legal: one bit per cycle, with no special case in the FSM.
- Changes to `D` after acceptance do not affect the frame in flight.
- `Q` and `Q_n` are registered outputs; there is no combinational path from the inputs to `Q`.

## Timing
- Name the accepting edge E0.
- `Q`=0 from E0 through E`CLKS_PER_BIT`.
- Data bit k is on `Q` from E((k+1)·`CLKS_PER_BIT`) through E((k+2)·`CLKS_PER_BIT`).
- Stop bit starts at E((`DATA_BITS`+1)·`CLKS_PER_BIT`).
- Frame length N = (`DATA_BITS`+2)·`CLKS_PER_BIT` cycles.
- `DONE`=1 between E(N-1) and EN.
- `READY` rises at EN.
- Back-to-back frames:
  - `LOAD`=1 held high is accepted at the first edge after EN.
  - The next start bit begins there, giving exactly one idle-high cycle between frames.
  - Sustained throughput is one frame per N+1 cycles.
- `READY` falls at E0, so the same word is never accepted twice.
- `Q_n` tracks `Q` on the same edge, never a cycle behind.

## Test plan
- **Reset defaults:** hold `CLR`=1 for 3 cycles with `LOAD`=1 → `Q`=1, `Q_n`=0, `READY`=1, `BUSY`=0, `DONE`=0 throughout, and no frame starts.
- **Single frame** (`DATA_BITS`=8, `CLKS_PER_BIT`=4): `D`=8'hA5 with one-cycle `LOAD`.
  - `Q` per 4-cycle bit = 0, 1,0,1,0,0,1,0,1, 1.
  - `DONE` is high only in cycle 40 after acceptance.
  - `READY` rises at E40.
- **Back-to-back:** `LOAD` held high with `D`=8'h00 then 8'hFF.
  - Two frames separated by exactly one idle-high cycle.
  - Second frame's data bits are all 1.
  - `DONE` pulses exactly twice.
- **Ignored load and stable data:** start `D`=8'h3C, then pulse `LOAD` and change `D`=8'hFF mid-frame.
  - Transmitted bits equal 8'h3C.
  - No second frame starts.
- **Reset mid-frame:** assert `CLR` for one cycle during data bit 3.
  - `Q`=1 and `READY`=1 at the next edge.
  - No `DONE` pulse.
  - A following `LOAD` of 8'h81 sends a complete, correct frame.
- **Minimum bit time** (`CLKS_PER_BIT`=1, `DATA_BITS`=4): `D`=4'b1001 → `Q` = 0,1,0,0,1,1 on consecutive cycles, and `DONE` falls in cycle 6.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter.
// Sends start bit, DATA_BITS data bits LSB first, then a stop bit.
module serial_frame_tx #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 LOAD,
  input  logic [DATA_BITS-1:0] D,
  output logic                 READY,
  output logic                 Q,
  output logic                 Q_n,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] T_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] T_ONE  = CW'(1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        tick_q;
  logic [CW-1:0]        tick_d;
  logic                 tick_end;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] sr_q;
  logic                 q_q;
  logic                 qn_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;

  // Bit-time counter end detect and wrapped next value.
  always_comb begin
    tick_end = (tick_q == T_LAST);
    tick_d   = tick_end ? '0 : tick_q + T_ONE;
  end

  // Frame FSM; every output is registered, Q_n written beside Q.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      q_q     <= 1'b1;
      qn_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (LOAD) begin
            state_q <= START;
            sr_q    <= D;
            tick_q  <= '0;
            bit_q   <= '0;
            q_q     <= 1'b0;
            qn_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          tick_q <= tick_d;
          if (tick_end) begin
            state_q <= DATA;
            q_q     <= sr_q[0];
            qn_q    <= ~sr_q[0];
            sr_q    <= sr_q >> 1;
            bit_q   <= '0;
          end
        end
        DATA: begin
          tick_q <= tick_d;
          if (tick_end) begin
            if (bit_q == B_LAST) begin
              state_q <= STOP;
              q_q     <= 1'b1;
              qn_q    <= 1'b0;
              done_q  <= (T_LAST == '0);
            end else begin
              q_q   <= sr_q[0];
              qn_q  <= ~sr_q[0];
              sr_q  <= sr_q >> 1;
              bit_q <= bit_q + B_ONE;
            end
          end
        end
        STOP: begin
          tick_q <= tick_d;
          if (tick_end) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            done_q <= (tick_d == T_LAST);
          end
        end
      endcase
    end
  end

  assign READY = ready_q;
  assign BUSY  = busy_q;
  assign Q     = q_q;
  assign Q_n   = qn_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed bench for serial_frame_tx.
// Two instances: 8 bits x 4 clocks, and 4 bits x 1 clock.
module tb_serial_frame_tx;

  logic       clk;
  logic       clr;
  logic       load1;
  logic [7:0] d1;
  logic       ready1, q1, qn1, busy1, done1;
  logic       load2;
  logic [3:0] d2;
  logic       ready2, q2, qn2, busy2, done2;

  int errs;
  int checks;

  serial_frame_tx #(
    .DATA_BITS(8),
    .CLKS_PER_BIT(4)
  ) dut1 (
    .CLK  (clk),
    .CLR  (clr),
    .LOAD (load1),
    .D    (d1),
    .READY(ready1),
    .Q    (q1),
    .Q_n  (qn1),
    .BUSY (busy1),
    .DONE (done1)
  );

  serial_frame_tx #(
    .DATA_BITS(4),
    .CLKS_PER_BIT(1)
  ) dut2 (
    .CLK  (clk),
    .CLR  (clr),
    .LOAD (load2),
    .D    (d2),
    .READY(ready2),
    .Q    (q2),
    .Q_n  (qn2),
    .BUSY (busy2),
    .DONE (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Called at E0+1; checks 40 cycles and the cycle after EN.
  task automatic run_frame(
    input  logic [7:0] data,
    input  int         disturb,
    input  string      name,
    output int         ndone
  );
    logic exp_q;
    int   bi;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      bi = c / 4;
      if (bi == 0) exp_q = 1'b0;
      else if (bi == 9) exp_q = 1'b1;
      else exp_q = data[bi-1];
      checks++;
      if (q1 !== exp_q || qn1 !== ~exp_q) begin
        errs++;
        $display("FAIL %s_q c=%0d got Q=%b Q_n=%b want Q=%b",
                 name, c, q1, qn1, exp_q);
      end
      checks++;
      if (done1 !== (c == 39)) begin
        errs++;
        $display("FAIL %s_done c=%0d got %b want %b",
                 name, c, done1, (c == 39));
      end
      checks++;
      if (ready1 !== 1'b0 || busy1 !== 1'b1) begin
        errs++;
        $display("FAIL %s_busy c=%0d got READY=%b BUSY=%b want 0/1",
                 name, c, ready1, busy1);
      end
      if (done1 === 1'b1) ndone++;
      if (c == disturb) begin
        d1    = 8'hFF;
        load1 = 1'b1;
      end else if (c == disturb + 1) begin
        load1 = 1'b0;
      end
      step();
    end
    checks++;
    if (ready1 !== 1'b1 || busy1 !== 1'b0 ||
        done1 !== 1'b0 || q1 !== 1'b1 || qn1 !== 1'b0) begin
      errs++;
      $display("FAIL %s_end got R=%b B=%b D=%b Q=%b Qn=%b want 1 0 0 1 0",
               name, ready1, busy1, done1, q1, qn1);
    end
  endtask

  task automatic test_reset;
    clr   = 1'b1;
    load1 = 1'b1;
    load2 = 1'b1;
    d1    = 8'hA5;
    d2    = 4'h9;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (q1 !== 1'b1 || qn1 !== 1'b0 || ready1 !== 1'b1 ||
          busy1 !== 1'b0 || done1 !== 1'b0) begin
        errs++;
        $display("FAIL reset1 i=%0d got Q=%b Qn=%b R=%b B=%b D=%b want 1 0 1 0 0",
                 i, q1, qn1, ready1, busy1, done1);
      end
      checks++;
      if (q2 !== 1'b1 || qn2 !== 1'b0 || ready2 !== 1'b1 ||
          busy2 !== 1'b0 || done2 !== 1'b0) begin
        errs++;
        $display("FAIL reset2 i=%0d got Q=%b Qn=%b R=%b B=%b D=%b want 1 0 1 0 0",
                 i, q2, qn2, ready2, busy2, done2);
      end
    end
    clr   = 1'b0;
    load1 = 1'b0;
    load2 = 1'b0;
    step();
    checks++;
    if (ready1 !== 1'b1 || q1 !== 1'b1 ||
        ready2 !== 1'b1 || q2 !== 1'b1) begin
      errs++;
      $display("FAIL reset_nostart got R1=%b Q1=%b R2=%b Q2=%b want 1 1 1 1",
               ready1, q1, ready2, q2);
    end
  endtask

  task automatic test_single_frame;
    int nd;
    d1    = 8'hA5;
    load1 = 1'b1;
    step();
    load1 = 1'b0;
    run_frame(8'hA5, -5, "single", nd);
    checks++;
    if (nd !== 1) begin
      errs++;
      $display("FAIL single_ndone got %0d want 1", nd);
    end
  endtask

  task automatic test_back_to_back;
    int n1;
    int n2;
    d1    = 8'h00;
    load1 = 1'b1;
    step();
    run_frame(8'h00, -5, "b2b0", n1);
    d1 = 8'hFF;
    step();
    load1 = 1'b0;
    run_frame(8'hFF, -5, "b2b1", n2);
    checks++;
    if (n1 + n2 !== 2) begin
      errs++;
      $display("FAIL b2b_ndone got %0d want 2", n1 + n2);
    end
  endtask

  task automatic test_ignored_load;
    int nd;
    d1    = 8'h3C;
    load1 = 1'b1;
    step();
    load1 = 1'b0;
    run_frame(8'h3C, 10, "ign", nd);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ready1 !== 1'b1 || q1 !== 1'b1) begin
        errs++;
        $display("FAIL ign_idle i=%0d got R=%b Q=%b want 1 1",
                 i, ready1, q1);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int nd;
    int bad;
    d1    = 8'h55;
    load1 = 1'b1;
    step();
    load1 = 1'b0;
    for (int c = 0; c < 17; c++) step();
    checks++;
    if (q1 !== 1'b0 || ready1 !== 1'b0) begin
      errs++;
      $display("FAIL mid_bit3 got Q=%b R=%b want 0 0", q1, ready1);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (q1 !== 1'b1 || qn1 !== 1'b0 || ready1 !== 1'b1 ||
        busy1 !== 1'b0 || done1 !== 1'b0) begin
      errs++;
      $display("FAIL mid_clr got Q=%b Qn=%b R=%b B=%b D=%b want 1 0 1 0 0",
               q1, qn1, ready1, busy1, done1);
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done1 !== 1'b0 || ready1 !== 1'b1 || q1 !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL mid_quiet got %0d bad cycles want 0", bad);
    end
    d1    = 8'h81;
    load1 = 1'b1;
    step();
    load1 = 1'b0;
    run_frame(8'h81, -5, "after_clr", nd);
  endtask

  task automatic test_min_bit_time;
    logic [5:0] expq;
    expq  = 6'b110010;
    d2    = 4'b1001;
    load2 = 1'b1;
    step();
    load2 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (q2 !== expq[c] || qn2 !== ~expq[c]) begin
        errs++;
        $display("FAIL min_q c=%0d got Q=%b Qn=%b want Q=%b",
                 c, q2, qn2, expq[c]);
      end
      checks++;
      if (done2 !== (c == 5) || ready2 !== 1'b0) begin
        errs++;
        $display("FAIL min_ctl c=%0d got D=%b R=%b want D=%b R=0",
                 c, done2, ready2, (c == 5));
      end
      step();
    end
    checks++;
    if (done2 !== 1'b0 || ready2 !== 1'b1 || q2 !== 1'b1) begin
      errs++;
      $display("FAIL min_end got D=%b R=%b Q=%b want 0 1 1",
               done2, ready2, q2);
    end
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    clr    = 1'b1;
    load1  = 1'b0;
    load2  = 1'b0;
    d1     = '0;
    d2     = '0;
    #1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignored_load();
    test_reset_mid_frame();
    test_min_bit_time();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
